// File: rtl/merge_4x1_if.sv
// ============================================================================
// merge_4x1_if : four-lane input / one-lane output stream bundle
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

interface merge_4x1_if #(
  parameter int WIDTH = 8
);
  logic [3:0]         in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_ready;

  // master: the environment that sources lanes and sinks the merged stream
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

`default_nettype wire

// File: rtl/merge_4x1.sv
// ============================================================================
// merge_4x1 : round-robin 4:1 stream merger with registered output and lane tag
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module merge_4x1 #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  merge_4x1_if.slave bus
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [1:0]       sel_q,   sel_d;
  logic [1:0]       ptr_q,   ptr_d;

  logic       load;
  logic       any_valid;
  logic [1:0] grant;
  logic [3:0] ready;

  // Scan from the highest offset down so the lane nearest ptr wins.
  always_comb begin : grant_scan
    any_valid = 1'b0;
    grant     = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (bus.in_valid[ptr_q + 2'(k)]) begin
        any_valid = 1'b1;
        grant     = ptr_q + 2'(k);
      end
    end
  end

  assign load = (state_q == EMPTY) | bus.out_ready;

  always_comb begin : ready_gen
    ready = 4'b0000;
    if (!rst && load && any_valid) begin
      ready[grant] = 1'b1;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (load) begin
      if (any_valid) begin
        state_d = FULL;
        data_d  = bus.in_data[int'(grant)*WIDTH +: WIDTH];
        sel_d   = grant;
        ptr_d   = grant + 2'd1;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= 2'b00;
      ptr_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;

endmodule

`default_nettype wire

// File: tb/tb_merge_4x1.sv
// ============================================================================
// tb_merge_4x1 : scoreboard bench for merge_4x1 (reference model + queue)
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_merge_4x1;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  merge_4x1_if #(.WIDTH(WIDTH)) bus ();
  merge_4x1 #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  logic [9:0]       sb[$];
  logic [9:0]       exp_w;
  logic [1:0]       m_ptr;
  logic             m_ov;
  logic [WIDTH-1:0] m_data;
  logic [1:0]       m_sel;
  bit               m_pushed;

  function automatic logic [3:0] m_ready();
    logic [1:0] idx;
    if (rst) return 4'b0000;
    if (m_ov && !bus.out_ready) return 4'b0000;
    for (int k = 0; k < 4; k++) begin
      idx = m_ptr + 2'(k);
      if (bus.in_valid[idx]) return 4'b0001 << idx;
    end
    return 4'b0000;
  endfunction

  // Advance the model by one edge using the inputs currently driven.
  task automatic tick();
    logic [3:0] r;
    logic [1:0] g;
    r = m_ready();
    m_pushed = 1'b0;
    if (rst) begin
      m_ov = 1'b0; m_ptr = 2'd0; m_data = '0; m_sel = 2'd0;
      sb.delete();
    end else if (!m_ov || bus.out_ready) begin
      if (r != 4'b0000) begin
        g = 2'd0;
        for (int k = 0; k < 4; k++) if (r[k]) g = 2'(k);
        m_data = bus.in_data[int'(g)*WIDTH +: WIDTH];
        m_sel  = g;
        m_ptr  = g + 2'd1;
        m_ov   = 1'b1;
        m_pushed = 1'b1;
        sb.push_back({g, m_data});
      end else begin
        m_ov = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 4'b1111;
    bus.in_data   = 32'h13121110;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (bus.in_ready !== 4'b0000) $display("FAIL reset_in_ready: got %b want 0000", bus.in_ready);
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({bus.out_valid, bus.out_sel, bus.out_data} !== 11'd0)
      $display("FAIL reset_out: got v=%b sel=%b data=%h want 0/00/00", bus.out_valid, bus.out_sel, bus.out_data);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 4'b0001 || m_ready() !== 4'b0001)
      $display("FAIL reset_first_grant: got %b want 0001", bus.in_ready);
    else n_pass++;
    tick();
    exp_w = sb.pop_front();
    n_checks++;
    if (bus.out_valid !== 1'b1 || {bus.out_sel, bus.out_data} !== exp_w)
      $display("FAIL reset_first_word: got v=%b %h want 1 %h", bus.out_valid, {bus.out_sel, bus.out_data}, exp_w);
    else n_pass++;
  endtask

  task automatic test_single_lane();
    bus.in_valid  = 4'b0000;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 4'b0100;
    bus.in_data  = '0;
    bus.in_data[2*WIDTH +: WIDTH] = 8'hA5;
    #1;
    n_checks++;
    if (bus.in_ready !== 4'b0100 || m_ready() !== 4'b0100)
      $display("FAIL single_in_ready: got %b want 0100", bus.in_ready);
    else n_pass++;
    tick();
    bus.in_valid = 4'b0000;
    exp_w = sb.pop_front();
    n_checks++;
    if (bus.out_valid !== 1'b1 || {bus.out_sel, bus.out_data} !== exp_w || exp_w !== 10'h2A5)
      $display("FAIL single_word: got v=%b %h want 1 2a5", bus.out_valid, {bus.out_sel, bus.out_data});
    else n_pass++;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL single_drain: got v=%b want 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_fairness();
    rst = 1'b1;
    bus.in_valid = 4'b0000;
    tick();
    rst = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.in_data   = 32'h13121110;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++;
      if (bus.in_ready !== m_ready()) $display("FAIL rr_in_ready[%0d]: got %b want %b", i, bus.in_ready, m_ready());
      else n_pass++;
      tick();
      exp_w = sb.pop_front();
      n_checks++;
      if (bus.out_valid !== 1'b1 || {bus.out_sel, bus.out_data} !== exp_w ||
          exp_w !== {2'(i % 4), 8'h10 + 8'(i % 4)})
        $display("FAIL rr_word[%0d]: got v=%b %h want 1 %h", i, bus.out_valid, {bus.out_sel, bus.out_data}, exp_w);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    bus.in_valid = 4'b0010;
    bus.in_data  = '0;
    bus.in_data[1*WIDTH +: WIDTH] = 8'h3C;
    bus.in_data[3*WIDTH +: WIDTH] = 8'hC3;
    bus.in_data[0 +: WIDTH]       = 8'h77;
    bus.out_ready = 1'b1;
    tick();
    exp_w = sb.pop_front();
    n_checks++;
    if ({bus.out_sel, bus.out_data} !== exp_w || exp_w !== {2'b01, 8'h3C})
      $display("FAIL bp_load: got %h want 13c", {bus.out_sel, bus.out_data});
    else n_pass++;
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus.in_ready !== 4'b0000 || m_ready() !== 4'b0000)
        $display("FAIL bp_in_ready[%0d]: got %b want 0000", i, bus.in_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || {bus.out_sel, bus.out_data} !== {m_sel, m_data} || bus.out_data !== 8'h3C)
        $display("FAIL bp_hold[%0d]: got v=%b %h want 1 13c", i, bus.out_valid, {bus.out_sel, bus.out_data});
      else n_pass++;
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 4'b1000 || m_ready() !== 4'b1000)
      $display("FAIL bp_release_grant: got %b want 1000", bus.in_ready);
    else n_pass++;
    tick();
    exp_w = sb.pop_front();
    n_checks++;
    if ({bus.out_sel, bus.out_data} !== exp_w || exp_w !== {2'b11, 8'hC3})
      $display("FAIL bp_release_word: got %h want %h", {bus.out_sel, bus.out_data}, exp_w);
    else n_pass++;
  endtask

  task automatic test_pointer_skip();
    bus.in_valid = 4'b0100;
    bus.in_data  = 32'h445A6677;
    #1;
    n_checks++;
    if (bus.in_ready !== 4'b0100 || m_ready() !== 4'b0100)
      $display("FAIL skip_grant: got %b want 0100", bus.in_ready);
    else n_pass++;
    tick();
    exp_w = sb.pop_front();
    n_checks++;
    if ({bus.out_sel, bus.out_data} !== exp_w || exp_w !== {2'b10, 8'h5A})
      $display("FAIL skip_word: got %h want %h", {bus.out_sel, bus.out_data}, exp_w);
    else n_pass++;
    // ptr is now 3: with every lane valid, lane 3 must win
    bus.in_valid = 4'b1111;
    #1;
    n_checks++;
    if (bus.in_ready !== 4'b1000 || m_ready() !== 4'b1000)
      $display("FAIL skip_ptr3: got %b want 1000", bus.in_ready);
    else n_pass++;
    tick();
    void'(sb.pop_front());
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1111;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 4'b0000) $display("FAIL mid_rst_ready0: got %b want 0000", bus.in_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 4'b0000)
      $display("FAIL mid_rst_state: got v=%b rdy=%b want 0 0000", bus.out_valid, bus.in_ready);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 4'b0001 || m_ready() !== 4'b0001)
      $display("FAIL mid_rst_ptr0: got %b want 0001", bus.in_ready);
    else n_pass++;
    tick();
    exp_w = sb.pop_front();
    n_checks++;
    if (bus.out_valid !== 1'b1 || {bus.out_sel, bus.out_data} !== exp_w)
      $display("FAIL mid_rst_word: got v=%b %h want 1 %h", bus.out_valid, {bus.out_sel, bus.out_data}, exp_w);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      bus.in_valid  = 4'($urandom_range(0, 15));
      bus.in_data   = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++;
      if (bus.in_ready !== m_ready()) $display("FAIL b2b_in_ready[%0d]: got %b want %b", i, bus.in_ready, m_ready());
      else n_pass++;
      tick();
      n_checks++;
      if (m_pushed) begin
        exp_w = sb.pop_front();
        if (bus.out_valid !== 1'b1 || {bus.out_sel, bus.out_data} !== exp_w)
          $display("FAIL b2b_word[%0d]: got v=%b %h want 1 %h", i, bus.out_valid, {bus.out_sel, bus.out_data}, exp_w);
        else n_pass++;
      end else begin
        if (bus.out_valid !== m_ov || (m_ov && {bus.out_sel, bus.out_data} !== {m_sel, m_data}))
          $display("FAIL b2b_hold[%0d]: got v=%b %h want %b %h", i, bus.out_valid, {bus.out_sel, bus.out_data}, m_ov, {m_sel, m_data});
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid  = 4'b0000;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    m_ptr = 2'd0; m_ov = 1'b0; m_data = '0; m_sel = 2'd0; m_pushed = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_lane();
    test_fairness();
    test_backpressure();
    test_pointer_skip();
    test_reset_midstream();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
